// File: rtl/systolic.sv
// ---------------------------------------------------------------------------
// systolic -- weight-stationary W x W systolic MAC array
//
// Each processing element PE[r][c] keeps a shadow weight (loaded from the
// top edge) and an active weight (used by the MAC).  A switch strobe that
// travels along the row with the data copies shadow into active, so new
// weights can be loaded while a stream is still running on the old ones.
//
// Data, valid and switch move right one PE per cycle.  Weight, index and
// accept move down one PE per cycle.  Partial sums and their valids move
// down one PE per cycle and leave through the bottom row.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   sys_data_in      [W*DATA_WIDTH_IN]     left-edge signed data, one lane per row
//   sys_valid_in     [W]                   left-edge data valid per row
//   sys_switch_in    [W]                   left-edge shadow->active strobe per row
//   sys_weight_in    [W*DATA_WIDTH_IN]     top-edge signed weight, one lane per column
//   sys_index_in     [W*$clog2(W)]         top-edge target row, one lane per column
//   sys_accept_w_in  [W]                   top-edge weight-load strobe per column
//   sys_data_out     [W*DATA_WIDTH_ACCUM]  bottom-edge signed partial sum per column
//   sys_valid_out    [W]                   bottom-edge valid per column
//   sys_enable_rows  [W]                   row enables
//   sys_enable_cols  [W]                   column enables; PE active iff both bits set
//
// Build option
//   SYSTOLIC_SAT_EN  defined: accumulation saturates at the signed
//                    DATA_WIDTH_ACCUM limits; undefined: two's-complement wrap.
//
// The array must be at least 2 x 2; DATA_WIDTH_ACCUM must be at least
// 2*DATA_WIDTH_IN so the full-precision product fits the accumulator.
// ---------------------------------------------------------------------------
module systolic #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 4,
    parameter int DATA_WIDTH_IN        = 8,
    parameter int DATA_WIDTH_ACCUM     = 32
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]          sys_data_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                        sys_valid_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                        sys_switch_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]          sys_weight_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH*$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] sys_index_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                        sys_accept_w_in,
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0]       sys_data_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                        sys_valid_out,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                        sys_enable_rows,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                        sys_enable_cols
);

    localparam int W     = SYSTOLIC_ARRAY_WIDTH;
    localparam int DIN   = DATA_WIDTH_IN;
    localparam int ACC   = DATA_WIDTH_ACCUM;
    localparam int IDX_W = $clog2(W);

    // Registered values leaving each PE towards its right-hand neighbour.
    // The last column has no right neighbour, so these are W x (W-1).
    logic signed [DIN-1:0]   data_fwd   [W][W-1];
    logic                    valid_fwd  [W][W-1];
    logic                    switch_fwd [W][W-1];

    // Registered weight-load traffic leaving each PE downwards.
    // The bottom row has no lower neighbour, so these are (W-1) x W.
    logic signed [DIN-1:0]   weight_fwd [W-1][W];
    logic [IDX_W-1:0]        index_fwd  [W-1][W];
    logic                    accept_fwd [W-1][W];

    // Registered partial sums / valids leaving each PE downwards.
    logic signed [ACC-1:0]   psum_fwd   [W][W];
    logic                    pvalid_fwd [W][W];

    genvar gi, gj;
    generate
        for (gi = 0; gi < W; gi++) begin : g_row
            for (gj = 0; gj < W; gj++) begin : g_col
                logic signed [DIN-1:0]   data_in;
                logic                    valid_in;
                logic                    switch_in;
                logic signed [DIN-1:0]   weight_in;
                logic [IDX_W-1:0]        index_in;
                logic                    accept_in;
                logic signed [ACC-1:0]   psum_in;
                logic                    valid_above;
                logic                    pe_en;
                logic signed [DIN-1:0]   w_eff;
                logic signed [2*DIN-1:0] prod;
                logic signed [ACC-1:0]   prod_ext;
                logic signed [ACC-1:0]   sum;
                logic signed [DIN-1:0]   shadow_reg;
                logic signed [DIN-1:0]   active_reg;
                logic signed [ACC-1:0]   psum_reg;
                logic                    pvalid_reg;

                // Left-edge PEs take the array inputs directly.
                if (gj == 0) begin : g_left
                    assign data_in   = sys_data_in[gi*DIN +: DIN];
                    assign valid_in  = sys_valid_in[gi];
                    assign switch_in = sys_switch_in[gi];
                end else begin : g_from_left
                    assign data_in   = data_fwd[gi][gj-1];
                    assign valid_in  = valid_fwd[gi][gj-1];
                    assign switch_in = switch_fwd[gi][gj-1];
                end

                // Top-row PEs take the array inputs directly and start the
                // partial-sum chain from zero.
                if (gi == 0) begin : g_top
                    assign weight_in   = sys_weight_in[gj*DIN +: DIN];
                    assign index_in    = sys_index_in[gj*IDX_W +: IDX_W];
                    assign accept_in   = sys_accept_w_in[gj];
                    assign psum_in     = '0;
                    assign valid_above = 1'b0;
                end else begin : g_from_above
                    assign weight_in   = weight_fwd[gi-1][gj];
                    assign index_in    = index_fwd[gi-1][gj];
                    assign accept_in   = accept_fwd[gi-1][gj];
                    assign psum_in     = psum_fwd[gi-1][gj];
                    assign valid_above = pvalid_fwd[gi-1][gj];
                end

                assign pe_en = sys_enable_rows[gi] & sys_enable_cols[gj];

                // A switch arriving with the data makes this very MAC use the
                // shadow weight, so the swap is seamless along the wavefront.
                assign w_eff    = switch_in ? shadow_reg : active_reg;
                assign prod     = (2*DIN)'(w_eff) * (2*DIN)'(data_in);
                assign prod_ext = ACC'(prod);

`ifdef SYSTOLIC_SAT_EN
                logic signed [ACC:0] sum_wide;
                assign sum_wide = {psum_in[ACC-1], psum_in} + {prod_ext[ACC-1], prod_ext};
                // Top two bits disagree only when the true sum left the
                // ACC-bit signed range; the top bit gives the direction.
                always_comb begin
                    sum = sum_wide[ACC-1:0];
                    if (sum_wide[ACC] != sum_wide[ACC-1]) begin
                        sum = sum_wide[ACC] ? {1'b1, {(ACC-1){1'b0}}}
                                            : {1'b0, {(ACC-1){1'b1}}};
                    end
                end
`else
                assign sum = psum_in + prod_ext;
`endif

                // Weight storage and the MAC / pass-through stage.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        shadow_reg <= '0;
                        active_reg <= '0;
                        psum_reg   <= '0;
                        pvalid_reg <= 1'b0;
                    end else begin
                        // Non-blocking order gives accept+switch in one cycle
                        // the old shadow in active and the new weight in shadow.
                        if (accept_in && (index_in == IDX_W'(gi))) begin
                            shadow_reg <= weight_in;
                        end
                        if (switch_in) begin
                            active_reg <= shadow_reg;
                        end
                        if (pe_en) begin
                            if (valid_in) begin
                                psum_reg   <= sum;
                                pvalid_reg <= 1'b1;
                            end else begin
                                psum_reg   <= '0;
                                pvalid_reg <= 1'b0;
                            end
                        end else begin
                            psum_reg   <= psum_in;
                            pvalid_reg <= valid_above;
                        end
                    end
                end

                assign psum_fwd[gi][gj]   = psum_reg;
                assign pvalid_fwd[gi][gj] = pvalid_reg;

                // Row traffic keeps flowing right whether or not the PE is enabled.
                if (gj < W-1) begin : g_right_reg
                    logic signed [DIN-1:0] data_reg;
                    logic                  valid_reg;
                    logic                  switch_reg;
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            data_reg   <= '0;
                            valid_reg  <= 1'b0;
                            switch_reg <= 1'b0;
                        end else begin
                            data_reg   <= data_in;
                            valid_reg  <= valid_in;
                            switch_reg <= switch_in;
                        end
                    end
                    assign data_fwd[gi][gj]   = data_reg;
                    assign valid_fwd[gi][gj]  = valid_reg;
                    assign switch_fwd[gi][gj] = switch_reg;
                end

                // Weight-load traffic keeps flowing down independent of enables.
                if (gi < W-1) begin : g_down_reg
                    logic signed [DIN-1:0] weight_reg;
                    logic [IDX_W-1:0]      index_reg;
                    logic                  accept_reg;
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            weight_reg <= '0;
                            index_reg  <= '0;
                            accept_reg <= 1'b0;
                        end else begin
                            weight_reg <= weight_in;
                            index_reg  <= index_in;
                            accept_reg <= accept_in;
                        end
                    end
                    assign weight_fwd[gi][gj] = weight_reg;
                    assign index_fwd[gi][gj]  = index_reg;
                    assign accept_fwd[gi][gj] = accept_reg;
                end
            end
        end

        for (gj = 0; gj < W; gj++) begin : g_out
            assign sys_data_out[gj*ACC +: ACC] = psum_fwd[W-1][gj];
            assign sys_valid_out[gj]           = pvalid_fwd[W-1][gj];
        end
    endgenerate

endmodule

// File: tb/tb_systolic.sv
// ---------------------------------------------------------------------------
// tb_systolic -- self-checking bench for systolic
//
// A 16-bit data width is used so four 32767*32767 products can push the
// 32-bit accumulator past its limit.  Expected column outputs are computed by
// a small weight model when each stream is driven, pushed per column together
// with the cycle they are due, and compared when that cycle arrives.
// ---------------------------------------------------------------------------
module tb_systolic;

    localparam int W   = 4;
    localparam int DIN = 16;
    localparam int ACC = 32;
    localparam int IW  = 2;
    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [W*DIN-1:0]     data_in;
    logic [W-1:0]         valid_in;
    logic [W-1:0]         switch_in;
    logic [W*DIN-1:0]     weight_in;
    logic [W*IW-1:0]      index_in;
    logic [W-1:0]         accept_in;
    logic [W*ACC-1:0]     data_out;
    logic [W-1:0]         valid_out;
    logic [W-1:0]         en_r;
    logic [W-1:0]         en_c;

    systolic #(
        .SYSTOLIC_ARRAY_WIDTH (W),
        .DATA_WIDTH_IN        (DIN),
        .DATA_WIDTH_ACCUM     (ACC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sys_data_in     (data_in),
        .sys_valid_in    (valid_in),
        .sys_switch_in   (switch_in),
        .sys_weight_in   (weight_in),
        .sys_index_in    (index_in),
        .sys_accept_w_in (accept_in),
        .sys_data_out    (data_out),
        .sys_valid_out   (valid_out),
        .sys_enable_rows (en_r),
        .sys_enable_cols (en_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model state: weights indexed [row][col], stream data [row][vector].
    longint shadow_m [W][W];
    longint active_m [W][W];
    longint ld_w     [W][W];
    longint bmat     [W][8];

    longint exp_val [W][$];
    int     exp_cyc [W][$];

    function automatic longint acc_step(input longint s, input longint p);
        longint t;
        t = s + p;
`ifdef SYSTOLIC_SAT_EN
        if (t > AMAX) t = AMAX;
        else if (t < AMIN) t = AMIN;
`else
        t = longint'(int'(t));
`endif
        return t;
    endfunction

    task automatic idle_inputs();
        data_in   = '0;
        valid_in  = '0;
        switch_in = '0;
        weight_in = '0;
        index_in  = '0;
        accept_in = '0;
    endtask

    // Streams nvec skewed data vectors from bmat (switch on the first beat
    // if sw), optionally loading ld_w into the shadows at the same time.
    task automatic run(input int nvec, input bit sw, input bit ld);
        int     steps;
        int     s_edge;
        int     n;
        longint s;
        steps = nvec + W - 1;
        if (ld && steps < W) steps = W;
        @(negedge clk);
        s_edge = cyc + 1;
        if (sw) active_m = shadow_m;
        for (int v = 0; v < nvec; v++) begin
            for (int c = 0; c < W; c++) begin
                if (en_c[c] && (|en_r)) begin
                    s = 0;
                    for (int k = 0; k < W; k++)
                        if (en_r[k]) s = acc_step(s, active_m[k][c] * bmat[k][v]);
                    exp_val[c].push_back(s);
                    exp_cyc[c].push_back(s_edge + v + c + W - 1);
                end
            end
        end
        if (ld) shadow_m = ld_w;
        for (int t = 0; t < steps; t++) begin
            if (t > 0) @(negedge clk);
            for (int k = 0; k < W; k++) begin
                n = t - k;
                if (n >= 0 && n < nvec) begin
                    valid_in[k]             = 1'b1;
                    data_in[k*DIN +: DIN]   = DIN'(bmat[k][n]);
                    switch_in[k]            = sw && (n == 0);
                end else begin
                    valid_in[k]             = 1'b0;
                    data_in[k*DIN +: DIN]   = '0;
                    switch_in[k]            = 1'b0;
                end
            end
            for (int c = 0; c < W; c++) begin
                if (ld && t < W) begin
                    accept_in[c]             = 1'b1;
                    index_in[c*IW +: IW]     = IW'(t);
                    weight_in[c*DIN +: DIN]  = DIN'(ld_w[t][c]);
                end else begin
                    accept_in[c]             = 1'b0;
                    index_in[c*IW +: IW]     = '0;
                    weight_in[c*DIN +: DIN]  = '0;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (2 * W) @(negedge clk);
    endtask

    task automatic fill_ld_random();
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                ld_w[r][c] = longint'(int'($urandom_range(600)) - 300);
    endtask

    task automatic fill_b_random(input int nvec);
        for (int k = 0; k < W; k++)
            for (int v = 0; v < nvec; v++)
                bmat[k][v] = longint'(int'($urandom_range(2000)) - 1000);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int c = 0; c < W; c++) begin
            check($sformatf("%s_data%0d", tag, c), longint'($signed(data_out[c*ACC +: ACC])), 0);
            check($sformatf("%s_valid%0d", tag, c), longint'(valid_out[c]), 0);
        end
    endtask

    // Scoreboard monitor: cycle-exact comparison of every expected output,
    // and any valid that nothing was expected for is reported.
    initial begin
        longint ev;
        int     ec;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int c = 0; c < W; c++) begin
                    if (exp_cyc[c].size() > 0 && exp_cyc[c][0] == cyc) begin
                        ev = exp_val[c].pop_front();
                        ec = exp_cyc[c].pop_front();
                        check($sformatf("valid_col%0d@%0d", c, ec), longint'(valid_out[c]), 1);
                        check($sformatf("data_col%0d@%0d", c, ec),
                              longint'($signed(data_out[c*ACC +: ACC])), ev);
                    end else if (valid_out[c]) begin
                        check($sformatf("spurious_valid_col%0d@%0d", c, cyc), longint'(valid_out[c]), 0);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en_r = '1;
        en_c = '1;
        idle_inputs();
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++) begin
                shadow_m[r][c] = 0;
                active_m[r][c] = 0;
            end
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Example 2x2 product on the upper-left corner: A[i][k] into column i
        // row k.  Disabled rows 2,3 carry junk that must not contribute;
        // columns 2,3 must never raise valid.  Gives 70,100 and 150,220.
        en_r = 4'b0011;
        en_c = 4'b0011;
        fill_ld_random();
        ld_w[0][0] = 1;  ld_w[1][0] = 2;
        ld_w[0][1] = 3;  ld_w[1][1] = 4;
        run(0, 1'b0, 1'b1);
        bmat[0][0] = 10; bmat[0][1] = 20;
        bmat[1][0] = 30; bmat[1][1] = 40;
        bmat[2][0] = 99; bmat[2][1] = 77;
        bmat[3][0] = -5; bmat[3][1] = 11;
        run(2, 1'b1, 1'b0);

        // Signed products on a single row: -128*-128, -1*5 and the cross terms.
        en_r = 4'b0001;
        en_c = 4'b0011;
        ld_w[0][0] = -128;
        ld_w[0][1] = -1;
        run(0, 1'b0, 1'b1);
        bmat[0][0] = -128;
        bmat[0][1] = 5;
        run(2, 1'b1, 1'b0);

        // Full array, random weights and data.
        en_r = '1;
        en_c = '1;
        fill_ld_random();
        run(0, 1'b0, 1'b1);
        fill_b_random(3);
        run(3, 1'b1, 1'b0);

        // Double buffering: new shadows load during a stream that must still
        // use the old active weights; the next switched stream uses the new.
        fill_ld_random();
        fill_b_random(4);
        run(4, 1'b0, 1'b1);
        fill_b_random(3);
        run(3, 1'b1, 1'b0);

        // Scattered enables: rows 1,3 and columns 1,2 only.
        en_r = 4'b1010;
        en_c = 4'b0110;
        fill_b_random(2);
        run(2, 1'b0, 1'b0);

        // Accumulator overflow: four 32767*32767 terms in column 0.
        en_r = '1;
        en_c = '1;
        fill_ld_random();
        for (int r = 0; r < W; r++) ld_w[r][0] = 32767;
        run(0, 1'b0, 1'b1);
        for (int k = 0; k < W; k++) bmat[k][0] = 32767;
        run(1, 1'b1, 1'b0);

        // Reset in the middle of a stream: outputs clear at once, nothing
        // in flight survives, and old weights are gone.
        fill_ld_random();
        run(0, 1'b0, 1'b1);
        fill_b_random(4);
        fork
            run(4, 1'b1, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_outputs_zero("midreset");
                for (int c = 0; c < W; c++) begin
                    exp_val[c].delete();
                    exp_cyc[c].delete();
                end
            end
        join
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++) begin
                shadow_m[r][c] = 0;
                active_m[r][c] = 0;
            end
        repeat (3 * W) @(negedge clk);

        // Reload without switching: active weights were cleared, so sums are 0;
        // then a switched stream picks up the newly loaded weights.
        fill_ld_random();
        fill_b_random(2);
        run(2, 1'b0, 1'b1);
        fill_b_random(2);
        run(2, 1'b1, 1'b0);

        repeat (2 * W) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
